// File: rtl/svga_cfg_pkg.sv
// Shared definitions for the SVGA configuration path: register map,
// reset defaults and the commit scheduler state encoding.
package svga_cfg_pkg;

   typedef enum logic [2:0] {
      REG_COLOR1   = 3'd0,
      REG_COLOR2   = 3'd1,
      REG_COLOR3   = 3'd2,
      REG_COLOR4   = 3'd3,
      REG_SPRITE_X = 3'd4,
      REG_SPRITE_Y = 3'd5,
      REG_MISC     = 3'd6,
      REG_RSVD     = 3'd7
   } reg_addr_e;

   localparam logic [5:0] COLOR1_DEF   = 6'b110001;
   localparam logic [5:0] COLOR2_DEF   = 6'b010101;
   localparam logic [5:0] COLOR3_DEF   = 6'b001100;
   localparam logic [5:0] COLOR4_DEF   = 6'b101100;
   localparam logic [7:0] SPRITE_X_DEF = 8'd0;
   localparam logic [7:0] SPRITE_Y_DEF = 8'd0;
   localparam logic [3:0] MISC_DEF     = 4'b0110;

   // FIFO entry is {address, data}.
   localparam int unsigned ENTRY_W = 11;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers so full and empty are
// distinguishable without a separate occupancy counter.
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define
   // which entries are valid, and this keeps the array a plain RAM.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/frame_commit_scheduler.sv
// Queues configuration writes and commits them to the live registers only
// during vertical blanking, at most COMMIT_LIMIT per blanking interval.
module frame_commit_scheduler
   import svga_cfg_pkg::*;
#(
   parameter int         DEPTH            = 8,
   parameter int         COMMIT_LIMIT     = 8,
   parameter logic [5:0] COLOR1_DEFAULT   = COLOR1_DEF,
   parameter logic [5:0] COLOR2_DEFAULT   = COLOR2_DEF,
   parameter logic [5:0] COLOR3_DEFAULT   = COLOR3_DEF,
   parameter logic [5:0] COLOR4_DEFAULT   = COLOR4_DEF,
   parameter logic [7:0] SPRITE_X_DEFAULT = SPRITE_X_DEF,
   parameter logic [7:0] SPRITE_Y_DEFAULT = SPRITE_Y_DEF,
   parameter logic [3:0] MISC_DEFAULT     = MISC_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [2:0]             wr_addr,
   input  logic [7:0]             wr_data,
   input  logic                   vblank,
   output logic [5:0]             color1,
   output logic [5:0]             color2,
   output logic [5:0]             color3,
   output logic [5:0]             color4,
   output logic [7:0]             sprite_x,
   output logic [7:0]             sprite_y,
   output logic [3:0]             misc,
   output logic [$clog2(DEPTH):0] pending,
   output logic                   frame_committed
);

   localparam logic [7:0] LIMIT_M1 = 8'(COMMIT_LIMIT - 1);

   state_e             state_q;
   state_e             state_d;
   logic               vblank_q;
   logic               blank_rise;
   logic [7:0]         commit_cnt;
   logic               push;
   logic               pop;
   logic               leave;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head;
   reg_addr_e          head_addr;

   assign wr_ready   = !fifo_full;
   assign push       = wr_valid && wr_ready;
   assign blank_rise = vblank && !vblank_q;
   assign head_addr  = reg_addr_e'(head[10:8]);

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (push),
      .pop    (pop),
      .wdata  ({wr_addr, wr_data}),
      .rdata  (head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (pending)
   );

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      leave   = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (blank_rise) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!vblank) begin
               state_d = ST_WAIT;
               leave   = 1'b1;
            end else if (!fifo_empty) begin
               pop = 1'b1;
               if (commit_cnt == LIMIT_M1) state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!vblank) begin
               state_d = ST_WAIT;
               leave   = 1'b1;
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q         <= ST_WAIT;
         vblank_q        <= 1'b0;
         commit_cnt      <= 8'd0;
         frame_committed <= 1'b0;
      end else begin
         state_q         <= state_d;
         vblank_q        <= vblank;
         frame_committed <= leave && (commit_cnt != 8'd0);
         if (state_q == ST_WAIT && blank_rise) commit_cnt <= 8'd0;
         else if (pop)                         commit_cnt <= commit_cnt + 8'd1;
      end
   end

   // Live registers update on the pop edge; narrower targets keep the low bits.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         color1   <= COLOR1_DEFAULT;
         color2   <= COLOR2_DEFAULT;
         color3   <= COLOR3_DEFAULT;
         color4   <= COLOR4_DEFAULT;
         sprite_x <= SPRITE_X_DEFAULT;
         sprite_y <= SPRITE_Y_DEFAULT;
         misc     <= MISC_DEFAULT;
      end else if (pop) begin
         case (head_addr)
            REG_COLOR1:   color1   <= head[5:0];
            REG_COLOR2:   color2   <= head[5:0];
            REG_COLOR3:   color3   <= head[5:0];
            REG_COLOR4:   color4   <= head[5:0];
            REG_SPRITE_X: sprite_x <= head[7:0];
            REG_SPRITE_Y: sprite_y <= head[7:0];
            REG_MISC:     misc     <= head[3:0];
            default:      ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_commit_scheduler.sv
// Scoreboard bench: stimulus queues the expected register snapshots for each
// blanking interval, a monitor compares them whenever the live state changes.
module tb_frame_commit_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       vblank;
   logic [5:0] color1, color2, color3, color4;
   logic [7:0] sprite_x, sprite_y;
   logic [3:0] misc;
   logic [3:0] pending;
   logic       frame_committed;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [5:0] c1;
      logic [5:0] c2;
      logic [5:0] c3;
      logic [5:0] c4;
      logic [7:0] sx;
      logic [7:0] sy;
      logic [3:0] misc;
      logic       fc;
   } snap_t;

   snap_t exp_q[$];
   snap_t mon_cur, mon_prev, mon_exp;

   logic [5:0] m_c1, m_c2, m_c3, m_c4;
   logic [7:0] m_sx, m_sy;
   logic [3:0] m_misc;

   always #5 clk = ~clk;

   frame_commit_scheduler #(
      .DEPTH        (8),
      .COMMIT_LIMIT (4)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .vblank          (vblank),
      .color1          (color1),
      .color2          (color2),
      .color3          (color3),
      .color4          (color4),
      .sprite_x        (sprite_x),
      .sprite_y        (sprite_y),
      .misc            (misc),
      .pending         (pending),
      .frame_committed (frame_committed)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      wr_addr  = a;
      wr_data  = d;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic model_reset();
      m_c1 = 6'b110001; m_c2 = 6'b010101; m_c3 = 6'b001100; m_c4 = 6'b101100;
      m_sx = 8'd0;      m_sy = 8'd0;      m_misc = 4'b0110;
   endtask

   function automatic snap_t model_snap(input logic fc);
      return '{c1: m_c1, c2: m_c2, c3: m_c3, c4: m_c4,
               sx: m_sx, sy: m_sy, misc: m_misc, fc: fc};
   endfunction

   // Expected effect of one commit; the reserved address changes nothing.
   task automatic exp_write(input logic [2:0] a, input logic [7:0] d);
      case (a)
         3'd0: m_c1   = d[5:0];
         3'd1: m_c2   = d[5:0];
         3'd2: m_c3   = d[5:0];
         3'd3: m_c4   = d[5:0];
         3'd4: m_sx   = d;
         3'd5: m_sy   = d;
         3'd6: m_misc = d[3:0];
         default: return;
      endcase
      exp_q.push_back(model_snap(1'b0));
   endtask

   task automatic exp_frame();
      exp_q.push_back(model_snap(1'b1));
   endtask

   task automatic window(input int n_high);
      vblank = 1'b1;
      repeat (n_high) tick();
      vblank = 1'b0;
      repeat (3) tick();
   endtask

   always @(negedge clk) begin
      mon_cur = '{c1: color1, c2: color2, c3: color3, c4: color4,
                  sx: sprite_x, sy: sprite_y, misc: misc, fc: frame_committed};
      if (!rst_n) begin
         mon_prev    = mon_cur;
         mon_prev.fc = 1'b0;
      end else if ({mon_cur[44:1], 1'b0} != mon_prev || mon_cur.fc) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %0h expected none", mon_cur);
         end else begin
            mon_exp = exp_q.pop_front();
            check("scoreboard", 64'(mon_cur), 64'(mon_exp));
         end
         mon_prev    = mon_cur;
         mon_prev.fc = 1'b0;
      end
   end

   initial begin
      rst_n = 1'b0; vblank = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_color1", color1, 6'h31);
      check("rst_color2", color2, 6'h15);
      check("rst_color3", color3, 6'h0C);
      check("rst_color4", color4, 6'h2C);
      check("rst_sprite_x", sprite_x, 8'd0);
      check("rst_sprite_y", sprite_y, 8'd0);
      check("rst_misc", misc, 4'h6);
      check("rst_pending", pending, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_frame_committed", frame_committed, 0);

      // A write outside blanking only queues.
      do_write(3'd0, 8'h3F);
      @(negedge clk);
      check("queued_pending", pending, 1);
      check("queued_color1_held", color1, 6'h31);
      exp_write(3'd0, 8'h3F);
      exp_frame();
      window(4);
      check("win0_pending", pending, 0);

      // Commit latency: output changes 2 cycles after vblank rises.
      do_write(3'd4, 8'd10);
      do_write(3'd5, 8'd20);
      do_write(3'd6, 8'h05);
      exp_write(3'd4, 8'd10);
      exp_write(3'd5, 8'd20);
      exp_write(3'd6, 8'h05);
      exp_frame();
      vblank = 1'b1;
      tick(); @(negedge clk); check("lat_rise1_sx", sprite_x, 8'd0);
      tick(); @(negedge clk); check("lat_rise2_sx", sprite_x, 8'd10);
      tick(); @(negedge clk); check("lat_rise3_sy", sprite_y, 8'd20);
      tick(); @(negedge clk); check("lat_rise4_misc", misc, 4'h5);
      check("lat_pending", pending, 0);
      check("lat_fc_during_blank", frame_committed, 0);
      vblank = 1'b0;
      tick(); @(negedge clk); check("fc_pulse_high", frame_committed, 1);
      tick(); @(negedge clk); check("fc_pulse_low", frame_committed, 0);

      // Fill to DEPTH, ninth write refused.
      do_write(3'd1, 8'h01); do_write(3'd2, 8'h02); do_write(3'd3, 8'h03);
      do_write(3'd4, 8'h40); do_write(3'd5, 8'h50); do_write(3'd6, 8'h09);
      do_write(3'd0, 8'h05); do_write(3'd1, 8'h06);
      @(negedge clk);
      check("full_pending", pending, 8);
      check("full_wr_ready", wr_ready, 0);
      do_write(3'd2, 8'h3E);
      @(negedge clk);
      check("ninth_ignored", pending, 8);
      exp_write(3'd1, 8'h01); exp_write(3'd2, 8'h02);
      exp_write(3'd3, 8'h03); exp_write(3'd4, 8'h40);
      exp_frame();
      vblank = 1'b1;
      tick(); @(negedge clk); check("full_before_pop", wr_ready, 0);
      tick(); @(negedge clk); check("ready_after_pop", wr_ready, 1);
      check("pending_after_pop", pending, 7);
      repeat (5) tick();
      @(negedge clk);
      check("limit_hold_pending", pending, 4);
      vblank = 1'b0;
      repeat (3) tick();
      exp_write(3'd5, 8'h50); exp_write(3'd6, 8'h09);
      exp_write(3'd0, 8'h05); exp_write(3'd1, 8'h06);
      exp_frame();
      window(6);
      check("full_drained", pending, 0);

      // Six queued with a limit of four: last sprite_x write wins this frame.
      do_write(3'd4, 8'h01); do_write(3'd4, 8'h02); do_write(3'd4, 8'h03);
      do_write(3'd4, 8'h04); do_write(3'd5, 8'h07); do_write(3'd3, 8'h11);
      exp_write(3'd4, 8'h01); exp_write(3'd4, 8'h02);
      exp_write(3'd4, 8'h03); exp_write(3'd4, 8'h04);
      exp_frame();
      window(8);
      check("limit_pending", pending, 2);
      check("limit_sprite_x", sprite_x, 8'h04);
      exp_write(3'd5, 8'h07); exp_write(3'd3, 8'h11);
      exp_frame();
      window(4);
      check("limit_rest_pending", pending, 0);
      check("limit_rest_sprite_y", sprite_y, 8'h07);
      check("limit_rest_color4", color4, 6'h11);

      // Reserved address: popped and counted, no register change.
      do_write(3'd7, 8'hFF);
      do_write(3'd1, 8'h2A);
      exp_write(3'd7, 8'hFF);
      exp_write(3'd1, 8'h2A);
      exp_frame();
      vblank = 1'b1;
      tick(); tick(); @(negedge clk);
      check("rsvd_color2_held", color2, 6'h06);
      check("rsvd_pending", pending, 1);
      tick(); @(negedge clk); check("rsvd_color2_new", color2, 6'h2A);
      tick(); @(negedge clk); check("rsvd_commit_cnt", dut.commit_cnt, 2);
      vblank = 1'b0;
      repeat (3) tick();

      // Reset mid-drain discards the queue and restores defaults.
      do_write(3'd6, 8'h01); do_write(3'd6, 8'h02); do_write(3'd6, 8'h03);
      do_write(3'd0, 8'h20); do_write(3'd0, 8'h21);
      @(negedge clk);
      check("pre_reset_pending", pending, 5);
      vblank = 1'b1;
      tick();
      rst_n = 1'b0;
      tick(); tick();
      @(negedge clk);
      check("midrst_pending", pending, 0);
      check("midrst_color1", color1, 6'h31);
      check("midrst_color2", color2, 6'h15);
      check("midrst_misc", misc, 4'h6);
      model_reset();
      rst_n = 1'b1;
      for (int w = 0; w < 2; w++) begin
         vblank = 1'b1;
         repeat (4) tick();
         vblank = 1'b0;
         for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("no_frame_pulse", frame_committed, 0);
         end
         vblank = 1'b0;
      end
      check("post_rst_pending", pending, 0);
      check("post_rst_misc", misc, 4'h6);

      repeat (2) tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
